// File: rtl/spi_regbank_pkg.sv
// Shared types and helpers for the SPI set/clear register bank.
package spi_regbank_pkg;

  localparam int unsigned SC_MAX_W = 32;
  localparam logic [SC_MAX_W-1:0] SOFT_RST_ONES = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADDR   = 2'd1,
    ST_DATA   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned reg_w);
    return addr_w + 2 * reg_w;
  endfunction

  // Soft-reset lives at the all-ones address of an addr_w-bit field.
  function automatic logic [SC_MAX_W-1:0] soft_rst_addr(input int unsigned addr_w);
    return SOFT_RST_ONES >> (SC_MAX_W - addr_w);
  endfunction

  // set-only sets, clear-only clears, both toggles, neither holds.
  function automatic logic [SC_MAX_W-1:0] sc_update(input logic [SC_MAX_W-1:0] x,
                                                    input logic [SC_MAX_W-1:0] s,
                                                    input logic [SC_MAX_W-1:0] c);
    return ((x | (s & ~c)) & ~(c & ~s)) ^ (s & c);
  endfunction

endpackage

// File: rtl/spi_regbank_sc_if.sv
// SPI pin bundle between a bus master and the register bank.
interface spi_regbank_sc_if;
  logic spi_clk;
  logic spi_cs;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_cs, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_cs, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus one edge-detect flop; rise/fall are single-clk pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], d_i};
  end

  assign rise_c_o =  sync_q[1] & ~sync_q[2];
  assign fall_c_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/spi_regbank_sc.sv
// SPI slave register bank with per-bit set/clear/toggle writes and readback,
// all pins oversampled in clk. Optional watchdog: SPI_REGBANK_WDOG_EN.
module spi_regbank_sc
  import spi_regbank_pkg::*;
#(
  parameter int unsigned            ADDR_W      = 8,
  parameter int unsigned            REG_W       = 4,
  parameter int unsigned            NREG        = 16,
  parameter logic [NREG*REG_W-1:0]  RESET_VAL   = '0,
  parameter logic [23:0]            WDOG_CYCLES = 24'd12_000_000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  spi_regbank_sc_if.slave        spi,
  output logic [NREG*REG_W-1:0]  reg_out,
  output logic                   frame_done,
  output logic                   frame_err,
  output logic                   wdog_trip
);

  localparam int unsigned FRAME_W = frame_w(ADDR_W, REG_W);
  localparam int unsigned DATA_W  = 2 * REG_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [ADDR_W-1:0] SOFT_RST_ADDR = ADDR_W'(soft_rst_addr(ADDR_W));

  typedef logic [NREG-1:0][REG_W-1:0] regs_t;

  logic sclk_rise_c, sclk_fall_c, cs_rise_c, cs_fall_c;
  logic [1:0] mosi_sync_q;
  logic       mosi_s;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] sh_in_q, sh_in_d;
  logic [DATA_W-1:0]  sh_out_q, sh_out_d;
  logic               miso_q, miso_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  regs_t              regs_q, regs_d, regs_in;
  logic               commit_ok_c;
  logic [ADDR_W-1:0]  rd_addr, wr_addr;
  logic [REG_W-1:0]   rd_val, wr_set, wr_clr;

  spi_sync_edge u_sclk_sync (.clk(clk), .rst_n(rst_n), .d_i(spi.spi_clk),
                             .rise_c_o(sclk_rise_c), .fall_c_o(sclk_fall_c));
  spi_sync_edge u_cs_sync   (.clk(clk), .rst_n(rst_n), .d_i(spi.spi_cs),
                             .rise_c_o(cs_rise_c), .fall_c_o(cs_fall_c));

  assign mosi_s = mosi_sync_q[1];

  // Readback lookup for the address completing on the current sclk rise.
  always_comb begin
    rd_addr = {sh_in_q[ADDR_W-2:0], mosi_s};
    rd_val  = '0;
    for (int unsigned k = 0; k < NREG; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_val = regs_q[k];
    end
  end

  assign wr_addr     = sh_in_q[FRAME_W-1 -: ADDR_W];
  assign wr_clr      = sh_in_q[DATA_W-1 -: REG_W];
  assign wr_set      = sh_in_q[REG_W-1:0];
  assign commit_ok_c = (state_q == ST_COMMIT) && (cnt_q == CNT_W'(FRAME_W));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_in_d  = sh_in_q;
    sh_out_d = sh_out_q;
    miso_d   = miso_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    regs_d   = regs_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cs_fall_c) begin
          cnt_d    = '0;
          sh_in_d  = '0;
          sh_out_d = '0;
          miso_d   = 1'b0;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (cs_rise_c) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise_c) begin
          sh_in_d = {sh_in_q[FRAME_W-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W - 1)) begin
            sh_out_d = {REG_W'(0), rd_val};
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (cs_rise_c) begin
          state_d = ST_COMMIT;
        end else begin
          if (sclk_rise_c) begin
            sh_in_d = {sh_in_q[FRAME_W-2:0], mosi_s};
            if (cnt_q != CNT_W'(FRAME_W + 1)) cnt_d = cnt_q + CNT_W'(1);
          end
          if (sclk_fall_c) begin
            miso_d   = sh_out_q[DATA_W-1];
            sh_out_d = {sh_out_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      ST_COMMIT: begin
        miso_d  = 1'b0;
        state_d = ST_IDLE;
        done_d  = commit_ok_c;
        err_d   = !commit_ok_c;
        if (commit_ok_c) begin
          if (wr_addr == SOFT_RST_ADDR) begin
            regs_d = regs_t'(RESET_VAL);
          end else begin
            for (int unsigned k = 0; k < NREG; k++) begin
              if (wr_addr == ADDR_W'(k))
                regs_d[k] = REG_W'(sc_update(SC_MAX_W'(regs_q[k]), SC_MAX_W'(wr_set),
                                             SC_MAX_W'(wr_clr)));
            end
          end
        end
      end
    endcase
  end

`ifdef SPI_REGBANK_WDOG_EN
  localparam logic [23:0] WDOG_LIM = WDOG_CYCLES - 24'd1;

  logic [23:0] wdog_cnt_q, wdog_cnt_d;
  logic        trip_q, trip_d;
  logic        wdog_fire_c;

  // A committed frame always wins over a simultaneous timeout.
  assign wdog_fire_c = (wdog_cnt_q == WDOG_LIM) && !commit_ok_c;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    trip_d     = trip_q;
    if (commit_ok_c) begin
      wdog_cnt_d = '0;
      trip_d     = 1'b0;
    end else if (wdog_cnt_q == WDOG_LIM) begin
      trip_d = 1'b1;
    end else begin
      wdog_cnt_d = wdog_cnt_q + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_cnt_q <= '0;
      trip_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      trip_q     <= trip_d;
    end
  end

  assign regs_in   = wdog_fire_c ? regs_t'(RESET_VAL) : regs_d;
  assign wdog_trip = trip_q;
`else
  assign regs_in   = regs_d;
  // Timeout value only matters when the watchdog is built in.
  assign wdog_trip = 1'b0 & (|WDOG_CYCLES);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sh_in_q     <= '0;
      sh_out_q    <= '0;
      miso_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      regs_q      <= regs_t'(RESET_VAL);
    end else begin
      mosi_sync_q <= {mosi_sync_q[0], spi.spi_mosi};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_in_q     <= sh_in_d;
      sh_out_q    <= sh_out_d;
      miso_q      <= miso_d;
      done_q      <= done_d;
      err_q       <= err_d;
      regs_q      <= regs_in;
    end
  end

  assign spi.spi_miso = miso_q;
  assign reg_out      = regs_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_spi_regbank_sc.sv
// Scoreboard bench for spi_regbank_sc; define SPI_REGBANK_WDOG_EN for the watchdog run.
module tb_spi_regbank_sc;

  localparam logic [63:0] RST_VAL = 64'h0000_0010_0000_0000;  // reg 9 bit 0 set
  localparam int unsigned HALF    = 4;
`ifdef SPI_REGBANK_WDOG_EN
  localparam logic [23:0] WDOG = 24'd100;
`else
  localparam logic [23:0] WDOG = 24'd12_000_000;
`endif

  typedef struct packed {
    logic        ok;
    logic [63:0] regs;
    logic [7:0]  miso;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] reg_out;
  logic        frame_done, frame_err, wdog_trip;
  logic [63:0] m_regs;
  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;

  spi_regbank_sc_if spi_if ();

  spi_regbank_sc #(.ADDR_W(8), .REG_W(4), .NREG(16), .RESET_VAL(RST_VAL), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .spi(spi_if), .reg_out(reg_out),
    .frame_done(frame_done), .frame_err(frame_err), .wdog_trip(wdog_trip));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model_write(input logic [63:0] cur, input logic [15:0] fr);
    logic [7:0]  a = fr[15:8];
    logic [3:0]  c = fr[7:4];
    logic [3:0]  s = fr[3:0];
    logic [63:0] r = cur;
    if (a == 8'hFF) return RST_VAL;
    if (a < 8'd16) begin
      for (int b = 0; b < 4; b++) begin
        int idx = int'(a) * 4 + b;
        case ({s[b], c[b]})
          2'b10:   r[idx] = 1'b1;
          2'b01:   r[idx] = 1'b0;
          2'b11:   r[idx] = ~r[idx];
          default: ;
        endcase
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] model_read(input logic [63:0] cur, input logic [7:0] a);
    if (a < 8'd16) return {4'b0, cur[int'(a) * 4 +: 4]};
    return 8'h00;
  endfunction

  // Mode-0 master; captures miso at each sclk rise. rst_after>0 pulses rst_n after that many bits.
  task automatic spi_xfer(input logic [31:0] bits, input int n, input int rst_after,
                          output logic [31:0] cap);
    cap = '0;
    @(negedge clk);
    spi_if.spi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi_if.spi_mosi = bits[i];
      repeat (HALF) @(negedge clk);
      spi_if.spi_clk = 1'b1;
      cap = {cap[30:0], spi_if.spi_miso};
      repeat (HALF) @(negedge clk);
      spi_if.spi_clk = 1'b0;
      if (n - i == rst_after) begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (HALF) @(negedge clk);
    spi_if.spi_cs = 1'b1;
  endtask

  task automatic collect(input string tag, input logic [7:0] miso_cap);
    exp_t        e = exp_q.pop_front();
    int          k = 0;
    logic        seen = 1'b0;
    logic [63:0] last_regs = reg_out;
    while (k < 12 && !seen) begin
      @(negedge clk);
      k++;
      seen = frame_done | frame_err;
      if (!seen) last_regs = reg_out;
    end
    check_eq({tag, " latency"}, 64'(k), 64'd4);
    check_eq({tag, " pre_regs"}, last_regs, m_regs);
    check_eq({tag, " done"}, 64'(frame_done), 64'(e.ok));
    check_eq({tag, " err"}, 64'(frame_err), 64'(!e.ok));
    check_eq({tag, " regs"}, reg_out, e.regs);
    if (e.ok) check_eq({tag, " miso"}, 64'(miso_cap), 64'(e.miso));
    @(negedge clk);
    check_eq({tag, " pulse_width"}, 64'({frame_done, frame_err}), 64'd0);
    m_regs = e.regs;
  endtask

  task automatic run_frame(input string tag, input logic [31:0] bits, input int n);
    exp_t        e;
    logic [31:0] cap;
    e.ok   = (n == 16);
    e.regs = e.ok ? model_write(m_regs, bits[15:0]) : m_regs;
    e.miso = model_read(m_regs, bits[n-1 -: 8]);
    exp_q.push_back(e);
    spi_xfer(bits, n, 0, cap);
    collect(tag, cap[7:0]);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (frame_done | frame_err) pulses++;
    end
    check_eq({tag, " pulses"}, 64'(pulses), 64'd0);
    check_eq({tag, " regs"}, reg_out, m_regs);
  endtask

  initial begin
    logic [31:0] cap;
    spi_if.spi_clk  = 1'b0;
    spi_if.spi_cs   = 1'b1;
    spi_if.spi_mosi = 1'b0;
    m_regs = RST_VAL;
    repeat (3) @(negedge clk);
    check_eq("rst reg_out", reg_out, RST_VAL);
    check_eq("rst miso", 64'(spi_if.spi_miso), 64'd0);
    check_eq("rst done", 64'(frame_done), 64'd0);
    check_eq("rst err", 64'(frame_err), 64'd0);
    check_eq("rst wdog", 64'(wdog_trip), 64'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

`ifdef SPI_REGBANK_WDOG_EN
    run_frame("wset", 32'h070F, 16);
    check_eq("wset trip", 64'(wdog_trip), 64'd0);
    repeat (98) @(negedge clk);
    check_eq("wdog hold regs", reg_out, m_regs);
    check_eq("wdog hold trip", 64'(wdog_trip), 64'd0);
    @(negedge clk);
    m_regs = RST_VAL;
    check_eq("wdog fire regs", reg_out, m_regs);
    check_eq("wdog fire trip", 64'(wdog_trip), 64'd1);
    run_frame("wclr", 32'h0700, 16);
    check_eq("wclr trip", 64'(wdog_trip), 64'd0);
`else
    run_frame("wr7", 32'h0703, 16);
    check_eq("wr7 nibble", 64'(reg_out[31:28]), 64'h3);
    run_frame("sc7", 32'h0712, 16);
    run_frame("tog7", 32'h0733, 16);
    run_frame("rd7", 32'h0700, 16);
    run_frame("rdhi", 32'h2000, 16);
    run_frame("rd9", 32'h0900, 16);
    run_frame("short12", 32'h0070, 12);
    run_frame("long17", 32'h0E1E, 17);

    for (int i = 0; i < 10; i++) begin
      spi_if.spi_mosi = i[0];
      spi_if.spi_clk  = 1'b1;
      repeat (HALF) @(negedge clk);
      spi_if.spi_clk  = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    quiet("cs_high_sclk", 8);

    run_frame("clr9", 32'h0910, 16);
    run_frame("wr0", 32'h000A, 16);
    run_frame("softrst", 32'hFF00, 16);
    run_frame("set7", 32'h070F, 16);

    spi_xfer(32'h0705, 16, 10, cap);
    m_regs = RST_VAL;
    quiet("midrst", 16);
    run_frame("post", 32'h0703, 16);
    check_eq("wdog off", 64'(wdog_trip), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_regbank_sc.md
Name: spi_regbank_sc

Overview:
- Parametrised successor to the SPI register bank: an SPI slave holding NREG control registers, each REG_W bits wide.
- Per-bit set/clear/toggle writes; every frame also reads back the addressed register.
- All SPI pins are oversampled in the system clock domain, so there are no SPI-clock-domain flops and no race between cs and sclk logic.
- Sits beside the cs/miso mux; reg_out fans out to LEDs, DAC control, ADC mode pins, etc.

Parameters:
- ADDR_W, 8, address field width (frame MSBs).
- REG_W, 4, register width. Data field is 2*REG_W: {clear_mask, set_mask}.
- NREG, 16, number of registers. Addresses 0..NREG-1; requires NREG < 2**ADDR_W.
- RESET_VAL, {NREG*REG_W{1'b0}}, flat per-register reset/soft-reset values. Register k occupies bits [k*REG_W +: REG_W].
- WDOG_CYCLES, 24'd12_000_000, watchdog timeout in clk cycles. Used only with SPI_REGBANK_WDOG_EN.

Ports:
- clk  in  1  system clock; must be at least 4x spi_clk.
- rst_n  in  1  asynchronous, active-low reset.
- spi_clk  in  1  SPI clock; mode 0, asynchronous to clk.
- spi_cs  in  1  active-low chip select.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- reg_out  out  NREG*REG_W  register contents, flat.
- frame_done  out  1  one-clk pulse on commit of a valid frame.
- frame_err  out  1  one-clk pulse on a discarded frame.
- wdog_trip  out  1  sticky watchdog flag; constant 0 when the feature is compiled out.

Behaviour:
- Reset: reg_out=RESET_VAL, spi_miso=0, frame_done=0, frame_err=0, wdog_trip=0. Bit counter, shift registers and FSM go to IDLE.
- Input conditioning:
  - spi_clk, spi_cs and spi_mosi each pass through a 2-flop synchronizer.
  - spi_clk and spi_cs additionally get a third flop for edge detect.
  - mosi is sampled on the synchronized sclk rising edge; spi_miso updates on the synchronized falling edge.
- Frame: FRAME_W = ADDR_W + 2*REG_W bits = {addr, clr[REG_W-1:0], set[REG_W-1:0]}. Bit count saturates at FRAME_W+1.
- FSM:
  - IDLE: on cs falling, clear bit count and shift register, drive spi_miso=0, go to ADDR.
  - ADDR: shift ADDR_W bits. At the rising edge that completes the address, load the output shift register with {REG_W'b0, reg[addr]}; for addr >= NREG, load 0. Go to DATA.
  - DATA: spi_miso presents the output shifter MSB-first, one bit per falling edge, starting with the falling edge after the last address bit. Keep shifting mosi.
  - COMMIT: entered on cs rising edge.
    - If count == FRAME_W: apply the write and pulse frame_done.
    - Otherwise (short or long frame): change nothing and pulse frame_err.
    - Then go to IDLE.
- cs rising edge in ADDR goes straight to the err path. sclk edges while cs is high are ignored. rst_n low mid-frame aborts the frame with nothing written.
- Write rule, per bit, with s = set, c = clr, x = current value:
  - s & ~c sets the bit.
  - c & ~s clears it.
  - s & c toggles it.
  - neither: hold.
  - Combined: new = ((x | (s & ~c)) & ~(c & ~s)) ^ (s & c).
- A frame with s = c = 0 is a pure read.
- Address map:
  - addr < NREG: that register.
  - addr == 2**ADDR_W-1: soft reset, all registers reload RESET_VAL.
  - Any other address: write ignored, readback 0, still counts as frame_done.
- Latency: reg_out changes on the 4th clk after the spi_cs pin rises (2 sync + 1 edge + 1 commit). frame_done is asserted in the same cycle reg_out updates.

Optional Feature:
- Macro: SPI_REGBANK_WDOG_EN.
- Defined:
  - A 24-bit counter runs from reset and clears on every frame_done.
  - When it reaches WDOG_CYCLES-1: all registers load RESET_VAL, wdog_trip sets, and the counter holds.
  - wdog_trip clears on the next frame_done.
  - Protects the rails/DAC when the MCU hangs.
- Undefined: no counter; wdog_trip tied 0.

Decomposition:
- Package spi_regbank_pkg:
  - function frame_w(ADDR_W, REG_W);
  - function sc_update(x, s, c) implementing the write rule;
  - localparam soft-reset address rule (all-ones);
  - FSM state typedef/encodings IDLE/ADDR/DATA/COMMIT.
- One sub-module: spi_sync_edge (2-flop sync plus rise/fall pulse outputs), instantiated for spi_clk and spi_cs.

Test Plan (all with default parameters):
- Write: reset, then frame 0x0703 on reg 7 -> reg_out[31:28]=4'h3 on the 4th clk after cs rises; one frame_done pulse.
- Set/clear: frame 0x0712 -> reg 7 = 4'h2.
- Toggle: frame 0x0733 -> reg 7 = 4'h1.
- Readback: frame 0x0700 -> MISO bits 8..15 = 8'h01 and reg 7 unchanged. Frame 0x2000 -> MISO data phase = 8'h00.
- Bad frame length: a 12-bit frame, then a 17-bit frame, each to addr 7 with set=4'hF -> no change and one frame_err pulse each. sclk toggling with cs high -> no effect.
- Soft reset: with RESET_VAL bit 0 of reg 9 = 1, send frame 0xFF00 -> all reg_out = RESET_VAL. Assert rst_n low mid-frame after 10 bits -> reset values, no commit.
- Watchdog (SPI_REGBANK_WDOG_EN, WDOG_CYCLES=100): set reg 7 = 4'hF, then idle 100 clks -> reg 7 = 0 and wdog_trip=1. The next valid frame clears wdog_trip.
